mimo_byte_merger: RTL

- Sits directly downstream of the 4-lane MIMO receiver top.
- Consumes the four per-antenna demapper byte streams (bits_out_N / bits_valid_N) and sync_found_combined.
- Buffers each lane in a small FIFO and merges the lanes round-robin into one byte stream with valid/ready backpressure.
- Tags the first byte of each lane after every sync rising edge as start-of-frame.

---
 rtl/rx_pkg.sv | 18 +
 rtl/lane_fifo.sv | 46 ++++
 rtl/mimo_byte_merger.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/rx_pkg.sv
// rtl/rx_pkg.sv - shared lane count, byte width, frame states and lane FIFO entry layout
package rx_pkg;

    localparam int LANES  = 4;
    localparam int BYTE_W = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        DRAIN  = 2'd2
    } frame_state_t;

    typedef struct packed {
        logic              sof;
        logic [BYTE_W-1:0] data;
    } lane_entry_t;

endpackage

// File: rtl/lane_fifo.sv
// rtl/lane_fifo.sv - per-lane synchronous FIFO with the head entry visible combinationally
// A write is still taken when full provided the head is popped in the same cycle.
module lane_fifo #(
    parameter int DEPTH = 8,
    parameter int W     = 9
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_wr_en,
    input  logic [W-1:0] i_wr_data,
    input  logic         i_rd_en,
    output logic [W-1:0] o_rd_data,
    output logic         o_empty,
    output logic         o_full
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] r_mem [DEPTH];
    logic [AW:0]  r_wr_ptr;
    logic [AW:0]  r_rd_ptr;
    logic         w_do_wr;
    logic         w_do_rd;

    // Extra pointer MSB distinguishes full from empty when the indices match.
    assign o_empty   = (r_wr_ptr == r_rd_ptr);
    assign o_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_do_rd   = i_rd_en & ~o_empty;
    assign w_do_wr   = i_wr_en & (~o_full | w_do_rd);
    assign o_rd_data = r_mem[r_rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_wr) r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
            if (w_do_rd) r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_wr) r_mem[r_wr_ptr[AW-1:0]] <= i_wr_data;
    end

endmodule

// File: rtl/mimo_byte_merger.sv
// rtl/mimo_byte_merger.sv - merges four demapper byte lanes round-robin into one stream
// Per-lane drop and handshake counters exist only when MIMO_MERGER_STATS_EN is defined.
module mimo_byte_merger #(
    parameter int FIFO_DEPTH = 8,
    parameter int BYTE_W     = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [BYTE_W-1:0] bits_in_0,
    input  logic [BYTE_W-1:0] bits_in_1,
    input  logic [BYTE_W-1:0] bits_in_2,
    input  logic [BYTE_W-1:0] bits_in_3,
    input  logic              bits_valid_0,
    input  logic              bits_valid_1,
    input  logic              bits_valid_2,
    input  logic              bits_valid_3,
    input  logic              sync_found_combined,
    output logic [BYTE_W-1:0] out_data,
    output logic [1:0]        out_lane,
    output logic              out_sof,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [3:0]        overflow,
    output logic              frame_active
`ifdef MIMO_MERGER_STATS_EN
    ,
    output logic [15:0]       drop_cnt_0,
    output logic [15:0]       drop_cnt_1,
    output logic [15:0]       drop_cnt_2,
    output logic [15:0]       drop_cnt_3,
    output logic [31:0]       byte_cnt
`endif
);
    import rx_pkg::*;

    frame_state_t      r_state, w_next_state;
    logic              r_sync_d;
    logic [LANES-1:0]  r_arm;
    logic [LANES-1:0]  r_overflow;
    logic [1:0]        r_rr_ptr;
    logic [BYTE_W-1:0] r_out_data;
    logic [1:0]        r_out_lane;
    logic              r_out_sof;
    logic              r_out_valid;

    logic              w_rise, w_fall, w_wr_window, w_load_en, w_found;
    logic [1:0]        w_grant;
    logic [LANES-1:0]  w_valid, w_empty, w_full, w_pop, w_accept, w_drop;
    logic [BYTE_W-1:0] w_bytes [LANES];
    lane_entry_t       w_wr_entry [LANES];
    lane_entry_t       w_rd_entry [LANES];

    assign w_rise      = sync_found_combined & ~r_sync_d;
    assign w_fall      = ~sync_found_combined & r_sync_d;
    assign w_wr_window = (r_state == ACTIVE) | w_rise;
    assign w_load_en   = ~r_out_valid | out_ready;
    assign w_valid     = {bits_valid_3, bits_valid_2, bits_valid_1, bits_valid_0};
    assign w_bytes[0]  = bits_in_0;
    assign w_bytes[1]  = bits_in_1;
    assign w_bytes[2]  = bits_in_2;
    assign w_bytes[3]  = bits_in_3;

    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next_state;
    end

    // A re-rise while draining wins over the drain-complete exit.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (w_rise) w_next_state = ACTIVE;
            ACTIVE:  if (w_fall) w_next_state = DRAIN;
            DRAIN: begin
                if (w_rise)                          w_next_state = ACTIVE;
                else if (&w_empty && !r_out_valid)   w_next_state = IDLE;
            end
            default: w_next_state = IDLE;
        endcase
    end

    always_comb begin
        frame_active = 1'b0;
        if (r_state == ACTIVE) frame_active = 1'b1;
    end

    // r_rr_ptr names the lane scanned first; it moves one past each grant.
    always_comb begin
        logic [1:0] v_idx;
        w_found = 1'b0;
        w_grant = 2'd0;
        v_idx   = 2'd0;
        for (int k = 0; k < LANES; k++) begin
            v_idx = r_rr_ptr + 2'(k);
            if (!w_found && !w_empty[v_idx]) begin
                w_found = 1'b1;
                w_grant = v_idx;
            end
        end
    end

    always_comb begin
        w_pop    = '0;
        w_accept = '0;
        w_drop   = '0;
        for (int i = 0; i < LANES; i++) begin
            w_pop[i]    = w_load_en & w_found & (w_grant == 2'(i));
            w_accept[i] = w_wr_window & w_valid[i] & (~w_full[i] | w_pop[i]);
            w_drop[i]   = w_wr_window & w_valid[i] & w_full[i] & ~w_pop[i];
        end
    end

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        assign w_wr_entry[g] = '{sof: r_arm[g] | w_rise, data: w_bytes[g]};

        lane_fifo #(
            .DEPTH (FIFO_DEPTH),
            .W     ($bits(lane_entry_t))
        ) u_fifo (
            .clk       (clk),
            .rst       (rst),
            .i_wr_en   (w_accept[g]),
            .i_wr_data (w_wr_entry[g]),
            .i_rd_en   (w_pop[g]),
            .o_rd_data (w_rd_entry[g]),
            .o_empty   (w_empty[g]),
            .o_full    (w_full[g])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync_d    <= 1'b0;
            r_arm       <= '0;
            r_overflow  <= '0;
            r_rr_ptr    <= 2'd0;
            r_out_data  <= '0;
            r_out_lane  <= 2'd0;
            r_out_sof   <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            r_sync_d   <= sync_found_combined;
            r_overflow <= r_overflow | w_drop;
            r_arm      <= (w_rise ? {LANES{1'b1}} : r_arm) & ~w_accept;
            if (w_load_en) begin
                r_out_valid <= w_found;
                if (w_found) begin
                    r_out_data <= w_rd_entry[w_grant].data;
                    r_out_sof  <= w_rd_entry[w_grant].sof;
                    r_out_lane <= w_grant;
                    r_rr_ptr   <= w_grant + 2'd1;
                end
            end
        end
    end

    assign out_data  = r_out_data;
    assign out_lane  = r_out_lane;
    assign out_sof   = r_out_sof;
    assign out_valid = r_out_valid;
    assign overflow  = r_overflow;

`ifdef MIMO_MERGER_STATS_EN
    logic [15:0] r_drop_cnt [LANES];
    logic [31:0] r_byte_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < LANES; i++) r_drop_cnt[i] <= '0;
            r_byte_cnt <= '0;
        end else begin
            for (int i = 0; i < LANES; i++) begin
                if (w_drop[i] && r_drop_cnt[i] != 16'hFFFF) r_drop_cnt[i] <= r_drop_cnt[i] + 16'd1;
            end
            if (r_out_valid && out_ready) r_byte_cnt <= r_byte_cnt + 32'd1;
        end
    end

    assign drop_cnt_0 = r_drop_cnt[0];
    assign drop_cnt_1 = r_drop_cnt[1];
    assign drop_cnt_2 = r_drop_cnt[2];
    assign drop_cnt_3 = r_drop_cnt[3];
    assign byte_cnt   = r_byte_cnt;
`endif

endmodule
